// File: rtl/decimal_entry_to_signed_if.sv
// Keypad-side bus for the decimal entry block: input strobes plus the
// committed value, status and echo digits.
interface decimal_entry_to_signed_if;
   logic       digit_valid;
   logic [3:0] digit;
   logic       neg_toggle;
   logic       enter;
   logic       clear;
   logic [7:0] val;
   logic       val_valid;
   logic       range_err;
   logic       ent_neg;
   logic [3:0] ent_hundreds;
   logic [3:0] ent_tens;
   logic [3:0] ent_ones;
   logic       busy;

   modport master (
      output digit_valid, digit, neg_toggle, enter, clear,
      input  val, val_valid, range_err, ent_neg,
             ent_hundreds, ent_tens, ent_ones, busy
   );

   modport slave (
      input  digit_valid, digit, neg_toggle, enter, clear,
      output val, val_valid, range_err, ent_neg,
             ent_hundreds, ent_tens, ent_ones, busy
   );
endinterface

// File: rtl/decimal_entry_to_signed.sv
// Decimal entry front end: collects an optional sign and up to three BCD
// digits, then commits them as an 8-bit two's-complement value with a
// -128..127 range check. All outputs are registered.
module decimal_entry_to_signed (
   input  logic                        clk,
   input  logic                        rst,
   decimal_entry_to_signed_if.slave    bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ENTRY = 2'd1,
      DONE  = 2'd2,
      ERROR = 2'd3
   } state_t;

   state_t     state;
   logic [1:0] count;
   logic [3:0] hund, tens, ones;
   logic       neg;
   logic [7:0] val_r;
   logic       val_valid_r;
   logic       range_err_r;
   logic       busy_r;

   logic [9:0] mag;
   logic       accept;
   logic [7:0] signed_val;
   logic       digit_ok;
   logic       open_entry;

   // Magnitude of the pending entry at full width (max 999), so the range
   // check sees values that would wrap in 8 bits.
   assign mag = 10'(hund) * 10'd100 + 10'(tens) * 10'd10 + 10'(ones);

   // Negative entries may reach 128 since -128 is representable.
   assign accept     = neg ? (mag <= 10'd128) : (mag <= 10'd127);
   assign signed_val = neg ? (~mag[7:0] + 8'd1) : mag[7:0];
   assign digit_ok   = (bus.digit <= 4'd9);
   assign open_entry = (state == IDLE) || (state == ENTRY);

   // Single-event-per-cycle FSM; clear > enter > neg_toggle > digit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         count       <= 2'd0;
         hund        <= 4'd0;
         tens        <= 4'd0;
         ones        <= 4'd0;
         neg         <= 1'b0;
         val_r       <= 8'h00;
         val_valid_r <= 1'b0;
         range_err_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         val_valid_r <= 1'b0;
         if (bus.clear) begin
            hund        <= 4'd0;
            tens        <= 4'd0;
            ones        <= 4'd0;
            neg         <= 1'b0;
            count       <= 2'd0;
            range_err_r <= 1'b0;
            busy_r      <= 1'b0;
            state       <= IDLE;
         end else if (bus.enter) begin
            if (open_entry) begin
               busy_r <= 1'b0;
               if (accept) begin
                  val_r       <= signed_val;
                  val_valid_r <= 1'b1;
                  state       <= DONE;
               end else begin
                  range_err_r <= 1'b1;
                  state       <= ERROR;
               end
            end
         end else if (bus.neg_toggle) begin
            if (open_entry) begin
               neg    <= ~neg;
               busy_r <= 1'b1;
               state  <= ENTRY;
            end
         end else if (bus.digit_valid && digit_ok) begin
            if (!open_entry) begin
               // Typing after a commit starts a fresh positive entry.
               hund        <= 4'd0;
               tens        <= 4'd0;
               ones        <= bus.digit;
               count       <= 2'd1;
               neg         <= 1'b0;
               range_err_r <= 1'b0;
               busy_r      <= 1'b1;
               state       <= ENTRY;
            end else if (count != 2'd3) begin
               hund   <= tens;
               tens   <= ones;
               ones   <= bus.digit;
               count  <= count + 2'd1;
               busy_r <= 1'b1;
               state  <= ENTRY;
            end
         end
      end
   end

   assign bus.val          = val_r;
   assign bus.val_valid    = val_valid_r;
   assign bus.range_err    = range_err_r;
   assign bus.ent_neg      = neg;
   assign bus.ent_hundreds = hund;
   assign bus.ent_tens     = tens;
   assign bus.ent_ones     = ones;
   assign bus.busy         = busy_r;

endmodule

// File: tb/tb_decimal_entry_to_signed.sv
// Directed bench for decimal_entry_to_signed with hand-computed expectations.
module tb_decimal_entry_to_signed;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fails;

   decimal_entry_to_signed_if bus ();

   decimal_entry_to_signed dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, got timeout, wanted completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: got 0x%0h, wanted 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic key(input logic [3:0] d);
      bus.digit       = d;
      bus.digit_valid = 1'b1;
      tick();
      bus.digit_valid = 1'b0;
   endtask

   task automatic do_enter();
      bus.enter = 1'b1;
      tick();
      bus.enter = 1'b0;
   endtask

   task automatic do_neg();
      bus.neg_toggle = 1'b1;
      tick();
      bus.neg_toggle = 1'b0;
   endtask

   task automatic do_clear();
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
   endtask

   task automatic check_echo(input string tag, input logic [3:0] h, input logic [3:0] t,
                             input logic [3:0] o);
      check({tag, ".h"}, 10'(bus.ent_hundreds), 10'(h));
      check({tag, ".t"}, 10'(bus.ent_tens), 10'(t));
      check({tag, ".o"}, 10'(bus.ent_ones), 10'(o));
   endtask

   initial begin
      n_checks       = 0;
      n_fails        = 0;
      rst            = 1'b1;
      bus.digit_valid = 1'b0;
      bus.digit      = 4'd0;
      bus.neg_toggle = 1'b0;
      bus.enter      = 1'b0;
      bus.clear      = 1'b0;
      #23;
      check("rst.val", 10'(bus.val), 10'h00);
      check("rst.vv", 10'(bus.val_valid), 10'd0);
      check("rst.err", 10'(bus.range_err), 10'd0);
      check("rst.neg", 10'(bus.ent_neg), 10'd0);
      check("rst.busy", 10'(bus.busy), 10'd0);
      check_echo("rst", 4'd0, 4'd0, 4'd0);
      rst = 1'b0;
      tick();

      // 127 positive; enter held two cycles gives a single pulse
      key(4'd1); key(4'd2); key(4'd7);
      check_echo("e127", 4'd1, 4'd2, 4'd7);
      check("e127.busy", 10'(bus.busy), 10'd1);
      bus.enter = 1'b1;
      tick();
      check("p127.val", 10'(bus.val), 10'h7F);
      check("p127.vv", 10'(bus.val_valid), 10'd1);
      check("p127.err", 10'(bus.range_err), 10'd0);
      check("p127.busy", 10'(bus.busy), 10'd0);
      tick();
      bus.enter = 1'b0;
      check("p127.vv2", 10'(bus.val_valid), 10'd0);
      check("p127.val2", 10'(bus.val), 10'h7F);

      // -128
      do_clear();
      check("clr.val", 10'(bus.val), 10'h7F);
      check_echo("clr", 4'd0, 4'd0, 4'd0);
      do_neg();
      check("n128.neg", 10'(bus.ent_neg), 10'd1);
      check("n128.busy", 10'(bus.busy), 10'd1);
      key(4'd1); key(4'd2); key(4'd8);
      do_enter();
      check("n128.val", 10'(bus.val), 10'h80);
      check("n128.vv", 10'(bus.val_valid), 10'd1);
      tick();
      check("n128.vv2", 10'(bus.val_valid), 10'd0);

      // -5
      do_clear();
      do_neg(); key(4'd5); do_enter();
      check("n5.val", 10'(bus.val), 10'hFB);
      check("n5.vv", 10'(bus.val_valid), 10'd1);

      // +128 rejected; fresh digit after DONE and after ERROR
      key(4'd1);
      check("fresh.neg", 10'(bus.ent_neg), 10'd0);
      check_echo("fresh", 4'd0, 4'd0, 4'd1);
      key(4'd2); key(4'd8);
      do_enter();
      check("p128.err", 10'(bus.range_err), 10'd1);
      check("p128.val", 10'(bus.val), 10'hFB);
      check("p128.vv", 10'(bus.val_valid), 10'd0);
      check("p128.busy", 10'(bus.busy), 10'd0);
      bus.neg_toggle = 1'b1;  // ignored in ERROR
      tick();
      bus.neg_toggle = 1'b0;
      check("err.neg", 10'(bus.ent_neg), 10'd0);
      key(4'd3);
      check("err3.err", 10'(bus.range_err), 10'd0);
      check_echo("err3", 4'd0, 4'd0, 4'd3);
      check("err3.busy", 10'(bus.busy), 10'd1);

      // overflow of digit count and illegal digit
      do_clear();
      key(4'd9); key(4'd9); key(4'd9); key(4'd4);
      check_echo("d999", 4'd9, 4'd9, 4'd9);
      key(4'hC);
      check_echo("dC", 4'd9, 4'd9, 4'd9);
      do_enter();
      check("p999.err", 10'(bus.range_err), 10'd1);
      check("p999.val", 10'(bus.val), 10'hFB);

      // priority: neg_toggle beats digit in the same cycle
      do_clear();
      bus.neg_toggle = 1'b1; bus.digit = 4'd5; bus.digit_valid = 1'b1;
      tick();
      bus.neg_toggle = 1'b0; bus.digit_valid = 1'b0;
      check("pri.neg", 10'(bus.ent_neg), 10'd1);
      check("pri.o", 10'(bus.ent_ones), 10'd0);

      // held digit shifts twice
      key(4'd4);
      bus.digit = 4'd2; bus.digit_valid = 1'b1;
      tick(); tick();
      bus.digit_valid = 1'b0;
      check_echo("held", 4'd4, 4'd2, 4'd2);

      // clear + enter together discards the entry
      do_clear();
      key(4'd4); key(4'd2);
      bus.clear = 1'b1; bus.enter = 1'b1;
      tick();
      bus.clear = 1'b0; bus.enter = 1'b0;
      check_echo("ce", 4'd0, 4'd0, 4'd0);
      check("ce.vv", 10'(bus.val_valid), 10'd0);
      check("ce.val", 10'(bus.val), 10'hFB);
      do_enter();
      check("bare.val", 10'(bus.val), 10'h00);
      check("bare.vv", 10'(bus.val_valid), 10'd1);

      // asynchronous reset mid-entry
      do_clear();
      key(4'd5); key(4'd6);
      check_echo("pre", 4'd0, 4'd5, 4'd6);
      #2;
      rst = 1'b1;
      #1;
      check_echo("arst", 4'd0, 4'd0, 4'd0);
      check("arst.busy", 10'(bus.busy), 10'd0);
      check("arst.val", 10'(bus.val), 10'h00);
      rst = 1'b0;
      tick();
      key(4'd3); do_enter();
      check("p3.val", 10'(bus.val), 10'h03);
      check("p3.vv", 10'(bus.val_valid), 10'd1);

      // -0 commits 0x00
      do_clear();
      do_neg(); do_enter();
      check("nz.val", 10'(bus.val), 10'h00);
      check("nz.vv", 10'(bus.val_valid), 10'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
